io_controller: RTL and testbench



---
 rtl/io_pkg.sv | 20 ++
 rtl/io_debounce.sv | 46 ++++
 rtl/io_controller.sv | 165 ++++++++++++++++
 tb/tb_io_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the switch/button/display I/O controller.
//   - opIo instruction codes (2'b11 is reserved and behaves like IO_NONE)
//   - FSM state encoding for IN sequencing
//   - switch bank width
package io_pkg;

    localparam logic [1:0] IO_NONE = 2'b00;
    localparam logic [1:0] IO_IN   = 2'b01;
    localparam logic [1:0] IO_OUT  = 2'b10;

    localparam int SWITCH_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_PRESS,
        DONE
    } io_state_e;

endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer followed by a level debouncer.
//   clock     in  system clock, rising edge
//   reset     in  synchronous, active-high
//   rawIn     in  raw asynchronous level
//   stableOut out debounced level; changes only after the synchronized input
//                 has disagreed with it for DEBOUNCE_CYCLES consecutive cycles
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic rawIn,
    output logic stableOut
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // sync_pipe[1] is the metastability-safe copy of rawIn
    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;
    logic          stable;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_pipe <= '0;
            cnt       <= '0;
            stable    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], rawIn};
            // any cycle of agreement restarts the count, so short glitches
            // never accumulate into a toggle
            if (sync_pipe[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stableOut = stable;

endmodule

// File: rtl/io_controller.sv
// io_controller: sequences CPU IN/OUT instructions on the switch/button/
// 7-segment path.
//   clock      in  system clock, rising edge
//   reset      in  synchronous, active-high
//   opIo       in  00 none, 01 IN, 10 OUT, 11 reserved (none)
//   switches   in  raw switch levels
//   button     in  raw asynchronous button, 1 = pressed
//   dataDisp   in  value latched into the display register on OUT
//   sIo        out captured IN value while opIo==IN, else 0
//   waitFlag   out CPU stall request during an IN
//   dispValue  out registered display value for the digit converter
//   ioTimeout  out one-cycle IN timeout pulse (only with IO_TIMEOUT_EN)
// Build option: define IO_TIMEOUT_EN to bound the IN wait to TIMEOUT_CYCLES;
// without it the IN wait is unbounded and TIMEOUT_CYCLES is unused.
module io_controller
    import io_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1000000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              opIo,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic                    button,
    input  logic [DATA_WIDTH-1:0]   dataDisp,
    output logic [DATA_WIDTH-1:0]   sIo,
    output logic                    waitFlag,
    output logic [DATA_WIDTH-1:0]   dispValue
`ifdef IO_TIMEOUT_EN
    ,
    output logic                    ioTimeout
`endif
);

    // elaboration-time parameter guards
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("io_controller: DEBOUNCE_CYCLES must be >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("io_controller: TIMEOUT_CYCLES must be >= 2");
    end

    io_state_e             state, next_state;
    logic                  btn_stable;
    logic [DATA_WIDTH-1:0] capture_reg;
    logic [DATA_WIDTH-1:0] disp_reg;
    logic                  capture_load;
    logic                  timeout_fire;
    logic                  timeout_hit;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .rawIn    (button),
        .stableOut(btn_stable)
    );

`ifdef IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;
    logic          timeout_q;
    logic          in_wait;

    assign in_wait     = (state == ARMED) || (state == WAIT_PRESS);
    assign timeout_hit = in_wait && (wait_cnt == WAIT_MAX);

    // restarts on every state change so both ARMED and WAIT_PRESS entries
    // begin a fresh window
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!in_wait || (next_state != state)) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            timeout_q <= timeout_fire;
        end
    end

    assign ioTimeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        capture_load = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                // a button already down must be released first, otherwise
                // one long press would satisfy back-to-back INs
                if (opIo == IO_IN) begin
                    next_state = btn_stable ? ARMED : WAIT_PRESS;
                end
            end
            ARMED: begin
                if (opIo != IO_IN) begin
                    next_state = IDLE;
                end else if (!btn_stable) begin
                    next_state = WAIT_PRESS;
                end else if (timeout_hit) begin
                    next_state   = DONE;
                    timeout_fire = 1'b1;
                end
            end
            WAIT_PRESS: begin
                if (opIo != IO_IN) begin
                    next_state = IDLE;
                end else if (btn_stable) begin
                    next_state   = DONE;
                    capture_load = 1'b1;
                end else if (timeout_hit) begin
                    next_state   = DONE;
                    timeout_fire = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            capture_reg <= '0;
            disp_reg    <= '0;
        end else begin
            if (capture_load) begin
                capture_reg <= DATA_WIDTH'(switches);
            end else if (timeout_fire) begin
                capture_reg <= '0;
            end
            if (opIo == IO_OUT) begin
                disp_reg <= dataDisp;
            end
        end
    end

    // stall includes the IDLE cycle where IN first appears; DONE releases it
    assign waitFlag  = (opIo == IO_IN) && (state != DONE);
    assign sIo       = (opIo == IO_IN) ? capture_reg : '0;
    assign dispValue = disp_reg;

endmodule

// File: tb/tb_io_controller.sv
module tb_io_controller;

    localparam int DW = 32;
    localparam int DB = 4;
    localparam int TO = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    opIo;
    logic [17:0]   switches;
    logic          button;
    logic [DW-1:0] dataDisp;
    logic [DW-1:0] sIo;
    logic          waitFlag;
    logic [DW-1:0] dispValue;
`ifdef IO_TIMEOUT_EN
    logic          ioTimeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    io_controller #(
        .DATA_WIDTH     (DW),
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .opIo     (opIo),
        .switches (switches),
        .button   (button),
        .dataDisp (dataDisp),
        .sIo      (sIo),
        .waitFlag (waitFlag),
        .dispValue(dispValue)
`ifdef IO_TIMEOUT_EN
        ,
        .ioTimeout(ioTimeout)
`endif
    );

    task automatic test_reset();
        reset    = 1'b1;
        opIo     = 2'b00;
        switches = '0;
        button   = 1'b0;
        dataDisp = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_cmp++; if (sIo !== 32'h0) begin n_bad++; $display("FAIL reset_sIo got %h want %h", sIo, 32'h0); end
        n_cmp++; if (waitFlag !== 1'b0) begin n_bad++; $display("FAIL reset_waitFlag got %b want 0", waitFlag); end
        n_cmp++; if (dispValue !== 32'h0) begin n_bad++; $display("FAIL reset_dispValue got %h want %h", dispValue, 32'h0); end
`ifdef IO_TIMEOUT_EN
        n_cmp++; if (ioTimeout !== 1'b0) begin n_bad++; $display("FAIL reset_ioTimeout got %b want 0", ioTimeout); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_out();
        @(negedge clock);
        opIo     = 2'b10;
        dataDisp = 32'd1234;
        #1;
        n_cmp++; if (waitFlag !== 1'b0) begin n_bad++; $display("FAIL out_waitFlag got %b want 0", waitFlag); end
        n_cmp++; if (sIo !== 32'h0) begin n_bad++; $display("FAIL out_sIo got %h want 0", sIo); end
        @(negedge clock);
        opIo     = 2'b00;
        dataDisp = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (dispValue !== 32'd1234) begin n_bad++; $display("FAIL out_latch got %0d want 1234", dispValue); end
        repeat (3) @(negedge clock);
        n_cmp++; if (dispValue !== 32'd1234) begin n_bad++; $display("FAIL out_hold got %h want %h", dispValue, 32'd1234); end
        n_cmp++; if (waitFlag !== 1'b0) begin n_bad++; $display("FAIL out_idle_waitFlag got %b want 0", waitFlag); end
    endtask

    // first IN, then the held-button second IN continues straight on
    task automatic test_in();
        int cyc;
        bit found;
        @(negedge clock);
        switches = 18'h2A5F3;
        opIo     = 2'b01;
        button   = 1'b0;
        #1;
        n_cmp++; if (waitFlag !== 1'b1) begin n_bad++; $display("FAIL in_first_cycle_wait got %b want 1", waitFlag); end
        repeat (3) @(negedge clock);
        n_cmp++; if (waitFlag !== 1'b1) begin n_bad++; $display("FAIL in_prepress_wait got %b want 1", waitFlag); end
        button = 1'b1;
        cyc = 0; found = 0;
        while (!found && cyc < 30) begin
            @(negedge clock);
            cyc++;
            if (waitFlag === 1'b0) found = 1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL in_done_seen got timeout after %0d cycles want release", cyc); end
        n_cmp++; if (cyc < 7) begin n_bad++; $display("FAIL in_latency got %0d cycles want >= 7", cyc); end
        n_cmp++; if (sIo !== 32'h0002A5F3) begin n_bad++; $display("FAIL in_capture got %h want %h", sIo, 32'h0002A5F3); end
        switches = 18'h00011;
        @(negedge clock);
        n_cmp++; if (waitFlag !== 1'b1) begin n_bad++; $display("FAIL in_done_one_cycle got %b want 1", waitFlag); end
    endtask

    task automatic test_held_button();
        int lows;
        int cyc;
        bit found;
        lows = 0;
        repeat (8) begin
            @(negedge clock);
            if (waitFlag !== 1'b1) lows++;
        end
        n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL held_no_capture got %0d released cycles want 0", lows); end
        button = 1'b0;
        lows = 0;
        repeat (8) begin
            @(negedge clock);
            if (waitFlag !== 1'b1) lows++;
        end
        n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL held_release_wait got %0d released cycles want 0", lows); end
        button = 1'b1;
        cyc = 0; found = 0;
        while (!found && cyc < 30) begin
            @(negedge clock);
            cyc++;
            if (waitFlag === 1'b0) found = 1;
        end
        n_cmp++; if (!found || cyc < 7) begin n_bad++; $display("FAIL held_repress_latency got %0d cycles (found=%0d) want >= 7", cyc, found); end
        n_cmp++; if (sIo !== 32'h00000011) begin n_bad++; $display("FAIL held_capture got %h want %h", sIo, 32'h00000011); end
        opIo   = 2'b00;
        button = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_bounce_reset();
        int lows;
        @(negedge clock);
        opIo     = 2'b01;
        switches = 18'h3FFFF;
        lows     = 0;
        for (int i = 0; i < 4; i++) begin
            button = 1'b1;
            repeat (2) begin @(negedge clock); if (waitFlag !== 1'b1) lows++; end
            button = 1'b0;
            repeat (3) begin @(negedge clock); if (waitFlag !== 1'b1) lows++; end
        end
        n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL bounce_wait got %0d released cycles want 0", lows); end
        n_cmp++; if (sIo !== 32'h00000011) begin n_bad++; $display("FAIL bounce_no_capture got %h want %h", sIo, 32'h00000011); end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (waitFlag !== 1'b1) begin n_bad++; $display("FAIL rst_mid_wait got %b want 1", waitFlag); end
        n_cmp++; if (sIo !== 32'h0) begin n_bad++; $display("FAIL rst_mid_sIo got %h want 0", sIo); end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (waitFlag !== 1'b1) begin n_bad++; $display("FAIL rst_reenter_wait got %b want 1", waitFlag); end
        opIo = 2'b00;
        #1;
        n_cmp++; if (waitFlag !== 1'b0) begin n_bad++; $display("FAIL rst_drop_wait got %b want 0", waitFlag); end
        repeat (2) @(negedge clock);
    endtask

`ifdef IO_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        bit found;
        @(negedge clock);
        opIo   = 2'b01;
        button = 1'b0;
        cyc = 0; found = 0;
        while (!found && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (waitFlag === 1'b0) found = 1;
        end
        n_cmp++; if (!found || cyc != 21) begin n_bad++; $display("FAIL timeout_latency got %0d cycles (found=%0d) want 21", cyc, found); end
        n_cmp++; if (ioTimeout !== 1'b1) begin n_bad++; $display("FAIL timeout_flag got %b want 1", ioTimeout); end
        n_cmp++; if (sIo !== 32'h0) begin n_bad++; $display("FAIL timeout_sIo got %h want 0", sIo); end
        @(negedge clock);
        n_cmp++; if (ioTimeout !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse got %b want 0", ioTimeout); end
        opIo = 2'b00;
        repeat (2) @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_out();
        test_in();
        test_held_button();
        test_bounce_reset();
`ifdef IO_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
